// File: rtl/alarm_ringer.sv
// Alarm ringer: IDLE/RING/SNOOZE controller with double-beep buzzer,
// auto-silence timeout and snooze countdown.
module alarm_ringer #(
    parameter int unsigned SNOOZE_SEC   = 300,
    parameter int unsigned RING_MAX_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_beep,
    input  logic       alarm_en,
    input  logic       alarm_arm,
    input  logic       key_stop,
    input  logic       key_snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [8:0] snooze_left
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC);
    localparam logic [6:0] RING_LAST   = 7'(RING_MAX_SEC - 1);

    state_e     state_q;
    logic       alarm_en_q;
    logic [6:0] ring_sec_q;
    logic [2:0] phase_q;
    logic [8:0] snooze_left_q;
    logic       rise;

    // Only a fresh rising edge of the match window may start ringing.
    assign rise = alarm_en & ~alarm_en_q;

    // State machine; priority is disarm, stop, snooze, then tick events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alarm_en_q    <= 1'b0;
            ring_sec_q    <= 7'd0;
            phase_q       <= 3'd0;
            snooze_left_q <= 9'd0;
        end else begin
            alarm_en_q <= alarm_en;
            if (!alarm_arm) begin
                state_q       <= IDLE;
                snooze_left_q <= 9'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q    <= RING;
                            ring_sec_q <= 7'd0;
                            phase_q    <= 3'd0;
                        end
                    end
                    RING: begin
                        if (key_stop) begin
                            state_q       <= IDLE;
                            snooze_left_q <= 9'd0;
                        end else if (key_snooze) begin
                            state_q       <= SNOOZE;
                            snooze_left_q <= SNOOZE_LOAD;
                        end else begin
                            if (tick_1hz) begin
                                // The timeout tick leaves RING, so no wrap.
                                if (ring_sec_q == RING_LAST) begin
                                    state_q <= IDLE;
                                end
                                ring_sec_q <= ring_sec_q + 7'd1;
                            end
                            if (tick_beep) begin
                                phase_q <= phase_q + 3'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (key_stop) begin
                            state_q       <= IDLE;
                            snooze_left_q <= 9'd0;
                        end else if (tick_1hz) begin
                            // Last second of snooze re-enters RING fresh.
                            if (snooze_left_q <= 9'd1) begin
                                state_q       <= RING;
                                ring_sec_q    <= 7'd0;
                                phase_q       <= 3'd0;
                                snooze_left_q <= 9'd0;
                            end else begin
                                snooze_left_q <= snooze_left_q - 9'd1;
                            end
                        end
                    end
                    default: begin
                        state_q       <= IDLE;
                        snooze_left_q <= 9'd0;
                    end
                endcase
            end
        end
    end

    // Outputs decoded purely from registered state.
    assign ringing     = (state_q == RING);
    assign snoozing    = (state_q == SNOOZE);
    assign snooze_left = snooze_left_q;
    assign buzzer      = ringing & ((phase_q == 3'd0) | (phase_q == 3'd2));

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: directed scenarios then random stimulus,
// compared each cycle against an event-level reference model.
module tb_alarm_ringer;

    localparam int SN = 3;
    localparam int RM = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_beep = 1'b0;
    logic       alarm_en = 1'b0;
    logic       alarm_arm = 1'b0;
    logic       key_stop = 1'b0;
    logic       key_snooze = 1'b0;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [8:0] snooze_left;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 idle, 1 ringing, 2 snoozing.
    int m_mode = 0;
    int m_secs = 0;
    int m_beeps = 0;
    int m_snz = 0;
    bit m_prev = 0;

    alarm_ringer #(
        .SNOOZE_SEC(SN),
        .RING_MAX_SEC(RM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_1hz(tick_1hz),
        .tick_beep(tick_beep),
        .alarm_en(alarm_en),
        .alarm_arm(alarm_arm),
        .key_stop(key_stop),
        .key_snooze(key_snooze),
        .buzzer(buzzer),
        .ringing(ringing),
        .snoozing(snoozing),
        .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs,
                         input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ph;
        logic exp_buz;
        ph = m_beeps % 8;
        exp_buz = (m_mode == 1) && (ph == 0 || ph == 2);
        check({tag, ".ringing"}, 9'(ringing), 9'(m_mode == 1));
        check({tag, ".snoozing"}, 9'(snoozing), 9'(m_mode == 2));
        check({tag, ".snooze_left"}, snooze_left, 9'(m_snz));
        check({tag, ".buzzer"}, 9'(buzzer), 9'(exp_buz));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_secs = 0;
        m_beeps = 0;
        m_snz = 0;
        m_prev = 0;
    endtask

    // Apply one clock edge of the alarm rules to the model.
    task automatic model_edge();
        bit rise;
        rise = alarm_en && !m_prev;
        if (!alarm_arm) begin
            m_mode = 0;
            m_snz = 0;
        end else if (m_mode == 0) begin
            if (rise) begin
                m_mode = 1;
                m_secs = 0;
                m_beeps = 0;
            end
        end else if (m_mode == 1) begin
            if (key_stop) begin
                m_mode = 0;
            end else if (key_snooze) begin
                m_mode = 2;
                m_snz = SN;
            end else begin
                if (tick_1hz) begin
                    m_secs++;
                    if (m_secs >= RM) m_mode = 0;
                end
                if (tick_beep) m_beeps++;
            end
        end else begin
            if (key_stop) begin
                m_mode = 0;
                m_snz = 0;
            end else if (tick_1hz) begin
                m_snz--;
                if (m_snz == 0) begin
                    m_mode = 1;
                    m_secs = 0;
                    m_beeps = 0;
                end
            end
        end
        m_prev = alarm_en;
    endtask

    // Drive one cycle: levels persist, pulses last a single edge.
    task automatic step(input string tag, input bit arm, input bit en,
                        input bit t1, input bit tb, input bit stp,
                        input bit snz);
        alarm_arm = arm;
        alarm_en = en;
        tick_1hz = t1;
        tick_beep = tb;
        key_stop = stp;
        key_snooze = snz;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        tick_1hz = 0;
        tick_beep = 0;
        key_stop = 0;
        key_snooze = 0;
    endtask

    initial begin
        #2;
        check_all("reset");
        #10;
        rst_n = 1'b1;
        step("idle", 1, 0, 0, 0, 0, 0);

        // Rise while armed rings after one edge; beep pattern 1,0,1,0.
        step("trigger", 1, 1, 0, 0, 0, 0);
        check("trigger.direct", 9'(ringing), 9'd1);
        for (int i = 0; i < 4; i++) step("beep", 1, 1, 0, 1, 0, 0);

        // Five seconds auto-silence; held alarm_en does not retrigger.
        for (int i = 0; i < 5; i++) step("timeout", 1, 1, 1, 0, 0, 0);
        check("timeout.direct", 9'(ringing), 9'd0);
        for (int i = 0; i < 3; i++) step("held", 1, 1, 0, 0, 0, 0);

        // Snooze countdown 3,2,1 then back to ringing.
        step("en_low", 1, 0, 0, 0, 0, 0);
        step("retrig", 1, 1, 0, 0, 0, 0);
        step("snooze", 1, 1, 0, 0, 0, 1);
        check("snooze.direct", snooze_left, 9'd3);
        for (int i = 0; i < 3; i++) step("snz_tick", 1, 1, 1, 0, 0, 0);
        check("snz_end.direct", 9'(ringing), 9'd1);

        // Stop beats snooze in the same cycle.
        step("stop_snz", 1, 1, 0, 0, 1, 1);
        check("stop_snz.direct", 9'(ringing | snoozing), 9'd0);

        // Snooze coincident with the timeout tick wins.
        step("en_low2", 1, 0, 0, 0, 0, 0);
        step("retrig2", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("pre_to", 1, 1, 1, 0, 0, 0);
        step("snz_vs_to", 1, 1, 1, 0, 0, 1);

        // Disarm during snooze forces idle and clears countdown.
        step("disarm", 0, 1, 0, 0, 0, 0);

        // Async reset mid-snooze, visible before any clock edge.
        step("rearm", 1, 0, 0, 0, 0, 0);
        step("retrig3", 1, 1, 0, 0, 0, 0);
        step("snooze3", 1, 1, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        alarm_en = 0;
        #2;
        rst_n = 1'b1;
        step("rst_snzkey", 1, 0, 0, 0, 0, 1);

        // Disarmed rise must not ring.
        step("noarm_rise", 0, 1, 0, 0, 0, 0);
        step("noarm_hold", 0, 1, 0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 $urandom_range(0, 31) != 0,
                 ($urandom_range(0, 11) == 0) ? !alarm_en : alarm_en,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter SNOOZE_SEC, default 300, snooze duration in seconds; legal range 1..511.
REQ-002 Parameter RING_MAX_SEC, default 60, auto-silence timeout in seconds; legal range 1..127.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-006 tick_beep  input  1  one-cycle pulse at beep-pattern rate (4 Hz nominal).
REQ-007 alarm_en  input  1  time-match window from the alarm comparator; level, high for the first 30 s of the matching minute.
REQ-008 alarm_arm  input  1  user switch, level; 1 = alarm armed.
REQ-009 key_stop  input  1  debounced one-cycle pulse, stop request.
REQ-010 key_snooze  input  1  debounced one-cycle pulse, snooze request.
REQ-011 buzzer  output  1  buzzer drive, double-beep pattern while ringing.
REQ-012 ringing  output  1  high in RING state.
REQ-013 snoozing  output  1  high in SNOOZE state.
REQ-014 snooze_left  output  9  seconds remaining in snooze; 0 outside SNOOZE.

Function
REQ-015 The block SHALL implement states IDLE, RING, SNOOZE with registered state; ringing = (state==RING), snoozing = (state==SNOOZE).
REQ-016 The block SHALL register alarm_en into alarm_en_d every cycle; rise = alarm_en & ~alarm_en_d.
REQ-017 IDLE -> RING SHALL occur on the edge where alarm_arm=1 and rise=1; ringing is high from that edge onward (one-edge latency).
REQ-018 A held-high alarm_en SHALL NOT retrigger; only a fresh rise enters RING.
REQ-019 On entry to RING the 7-bit ring-second counter and 3-bit beep-phase counter SHALL clear to 0.
REQ-020 In RING, ring-second counter SHALL increment on tick_1hz; the tick that makes it equal RING_MAX_SEC SHALL move state to IDLE.
REQ-021 In RING, beep phase SHALL increment modulo 8 on tick_beep; buzzer = ringing & (phase==0 | phase==2), decoded from registered state.
REQ-022 RING + key_snooze SHALL move to SNOOZE and load snooze_left = SNOOZE_SEC.
REQ-023 In SNOOZE, snooze_left SHALL decrement on tick_1hz; a tick with snooze_left==1 SHALL move to RING (counters cleared per REQ-019) and set snooze_left = 0.
REQ-024 key_snooze in SNOOZE or IDLE, and rise in RING or SNOOZE, SHALL be ignored.
REQ-025 key_stop in RING or SNOOZE SHALL move to IDLE and clear snooze_left.
REQ-026 alarm_arm=0 SHALL force IDLE from any state on the next edge and clear snooze_left.
REQ-027 Same-cycle priority SHALL be: alarm_arm=0 > key_stop > key_snooze > tick-driven transitions.
REQ-028 key_snooze coincident with the RING timeout tick SHALL enter SNOOZE (snooze beats timeout).
REQ-029 Counters SHALL never wrap: ring-second counter saturates by leaving RING; snooze_left never goes below 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, alarm_en_d=0, all counters=0, snooze_left=0; buzzer, ringing, snoozing = 0.
REQ-031 Reset asserted mid-RING or mid-SNOOZE SHALL abort immediately; after release a still-high alarm_en SHALL NOT ring until alarm_en_d has sampled it (i.e. rise seen on first edge after release only if alarm_en is high then — this is a legal trigger).

Verification (SNOOZE_SEC=3, RING_MAX_SEC=5 unless stated)
REQ-032 arm=1, alarm_en 0->1 -> ringing=1 after one edge; tick_beep x4 -> buzzer pattern 1,0,1,0 across phases 0..3.
REQ-033 Ringing, five tick_1hz, no keys -> IDLE after fifth tick; alarm_en still high -> stays IDLE.
REQ-034 Ringing, key_snooze -> snoozing=1, snooze_left=3; three tick_1hz -> 2,1, then ringing=1, snooze_left=0.
REQ-035 key_stop and key_snooze same cycle in RING -> IDLE; alarm_arm=0 during SNOOZE -> IDLE, snooze_left=0.
REQ-036 rst_n pulsed low mid-SNOOZE -> all outputs 0 without a clock edge; recovery ignores key_snooze in IDLE.
REQ-037 arm=0 with alarm_en rising -> stays IDLE, buzzer=0.
